// File: rtl/countdown_timer_ctrl.sv
// Run/pause/stop countdown controller with a built-in prescaler.
// It counts a loaded value down to zero, one step per prescaler tick.
module countdown_timer_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [PS_W-1:0]   prescaler;

    assign state = state_r;

    // The prescaler still advances on the cycle a pause is sampled. A wrap on
    // the final count goes to DONE, even if a pause arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (clear) begin
                state_r   <= IDLE;
                remaining <= '0;
                prescaler <= '0;
                busy      <= 1'b0;
            end else if (load) begin
                state_r   <= IDLE;
                remaining <= load_val;
                prescaler <= '0;
                busy      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && (remaining != '0)) begin
                            state_r <= RUN;
                            busy    <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            tick      <= 1'b1;
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                state_r <= DONE;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                            end else if (pause) begin
                                state_r <= PAUSE;
                            end
                        end else begin
                            prescaler <= prescaler + PS_W'(1);
                            if (pause) begin
                                state_r <= PAUSE;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state_r <= RUN;
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: directed commands push expected
// tick records, and a monitor checks each tick as the DUT produces it.
module tb_countdown_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 16;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             start;
    logic             pause;
    logic             clear;
    logic             tick;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] rem;
        logic             dn;
        logic [1:0]       st;
        logic             bsy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc;
    int   vectors;
    int   miscompares;

    countdown_timer_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .tick      (tick),
        .remaining (remaining),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Each call presents one command set for exactly one rising edge and
    // returns the number of the edge that sampled it.
    task automatic apply_stimulus(input logic c, input logic l, input logic p, input logic s,
                                  input logic [CNT_W-1:0] v, output int n);
        @(negedge clk);
        clear = c; load = l; pause = p; start = s; load_val = v;
        @(posedge clk);
        #1;
        n = cyc;
        clear = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
    endtask

    task automatic idle(input int k);
        int n;
        repeat (k) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, n);
    endtask

    task automatic push_exp(input int c, input logic [CNT_W-1:0] r, input logic d,
                            input logic [1:0] s, input logic b);
        exp_t e;
        e.cyc = c; e.rem = r; e.dn = d; e.st = s; e.bsy = b;
        exp_q.push_back(e);
    endtask

    task automatic check_status(input string tag, input logic [1:0] s, input logic [CNT_W-1:0] r,
                                input logic b);
        check_output({tag, "_state"}, 32'(state), 32'(s));
        check_output({tag, "_remaining"}, 32'(remaining), 32'(r));
        check_output({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    // The monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tick) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_tick: tick=1 remaining=%0d at edge %0d, expected no tick",
                             remaining, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("tick_edge", 32'(cyc), 32'(mon_e.cyc));
                    check_output("tick_remaining", 32'(remaining), 32'(mon_e.rem));
                    check_output("tick_done", 32'(done), 32'(mon_e.dn));
                    check_output("tick_state", 32'(state), 32'(mon_e.st));
                    check_output("tick_busy", 32'(busy), 32'(mon_e.bsy));
                end
            end else if (done) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL done_without_tick: done=1 at edge %0d, expected 0", cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int n2;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset", 2'd0, '0, 1'b0);
        check_output("reset_tick", 32'(tick), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] start with nothing loaded");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        check_status("empty_start", 2'd0, '0, 1'b0);
        idle(20);
        check_status("empty_start_later", 2'd0, '0, 1'b0);

        $display("[TB] load 3 and count out");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd3, n);
        check_status("load3", 2'd0, 16'd3, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        check_status("run3", 2'd1, 16'd3, 1'b1);
        push_exp(n + 4, 16'd2, 1'b0, 2'd1, 1'b1);
        push_exp(n + 8, 16'd1, 1'b0, 2'd1, 1'b1);
        push_exp(n + 12, 16'd0, 1'b1, 2'd3, 1'b0);
        idle(14);
        check_status("done3", 2'd3, '0, 1'b0);
        check_output("done3_pulse_gone", 32'(done), 32'd0);

        $display("[TB] re-arm from DONE");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        idle(6);
        check_status("done_start_ignored", 2'd3, '0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd1, n);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        push_exp(n + 4, 16'd0, 1'b1, 2'd3, 1'b0);
        idle(6);
        check_status("rearm_done", 2'd3, '0, 1'b0);

        $display("[TB] pause and resume");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, n);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        idle(1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, n2);
        check_status("paused", 2'd2, 16'd2, 1'b1);
        idle(4);
        check_status("paused_hold", 2'd2, 16'd2, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n2);
        check_output("resume_edge", 32'(n2), 32'(n + 7));
        push_exp(n + 9, 16'd1, 1'b0, 2'd1, 1'b1);
        push_exp(n + 13, 16'd0, 1'b1, 2'd3, 1'b0);
        idle(8);
        check_status("pause_done", 2'd3, '0, 1'b0);

        $display("[TB] simultaneous commands during RUN");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, n);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        idle(1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'd7, n);
        check_status("clear_wins", 2'd0, '0, 1'b0);
        idle(8);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, n);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        idle(1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd10, n);
        check_status("load_in_run", 2'd0, 16'd10, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        push_exp(n + 4, 16'd9, 1'b0, 2'd1, 1'b1);
        idle(5);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, n);
        check_status("clear_after_tick", 2'd0, '0, 1'b0);
        idle(8);

        $display("[TB] reset mid-run");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd5, n);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, n);
        idle(1);
        check_status("pre_reset", 2'd1, 16'd5, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("async_reset", 2'd0, '0, 1'b0);
        check_output("async_reset_tick", 32'(tick), 32'd0);
        check_output("async_reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check_status("post_reset", 2'd0, '0, 1'b0);

        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_tick: no tick seen, expected one at edge %0d with remaining %0d",
                     mon_e.cyc, mon_e.rem);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
